// File: rtl/n0_sched.sv
// Issue scheduler for the n0 multiplier cluster: walks tiles x chunks, drives
// NBin/SB reads under downstream credit control and aligns valid/first/last with products.
module n0_sched #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned LAT     = 5,
    parameter int unsigned CREDITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_in,
    input  logic [CNT_W-1:0]  i_num_out,
    input  logic [ADDR_W-1:0] i_nbin_base,
    input  logic [ADDR_W-1:0] i_sb_base,
    input  logic              i_credit,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_nbin_rd,
    output logic [ADDR_W-1:0] o_nbin_addr,
    output logic              o_sb_rd,
    output logic [ADDR_W-1:0] o_sb_addr,
    output logic              o_valid,
    output logic              o_first,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_credits
);

    localparam int unsigned D = LAT + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]  num_in_q, num_out_q;
    logic [CNT_W-1:0]  in_idx_q, out_idx_q;
    logic [ADDR_W-1:0] nbin_base_q, sb_base_q, sb_ofs_q;
    logic [CNT_W-1:0]  credits_q, credits_d;
    logic              rd_q;
    logic              iss_first_q, iss_last_q, iss_end_q;
    logic [D-1:0]      pv_q, pf_q, pl_q;

    logic              start_c;
    logic              issue_c;
    logic              in_last_c, out_last_c;
    logic [CNT_W-1:0]  num_in_e, num_out_e, in_idx_e, out_idx_e;
    logic [ADDR_W-1:0] nbin_base_e, sb_base_e, sb_ofs_e;

    // Pass sequencing; the drain exits once only the output stage may still hold a valid.
    always_comb begin
        state_d = state;
        start_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_c = 1'b1;
                    if ((i_num_in == '0) || (i_num_out == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (rd_q && iss_end_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pv_q[D-2:0] == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Credit accounting; a freed slot at full count is dropped.
    always_comb begin
        credits_d = credits_q;
        if (rd_q && !i_credit) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (!rd_q && i_credit && (credits_q != CNT_W'(CREDITS))) begin
            credits_d = credits_q + CNT_W'(1);
        end
    end

    // Issue decision is made one cycle ahead so strobes and addresses come straight from flops.
    always_comb begin
        num_in_e    = start_c ? i_num_in    : num_in_q;
        num_out_e   = start_c ? i_num_out   : num_out_q;
        nbin_base_e = start_c ? i_nbin_base : nbin_base_q;
        sb_base_e   = start_c ? i_sb_base   : sb_base_q;
        in_idx_e    = start_c ? '0 : in_idx_q;
        out_idx_e   = start_c ? '0 : out_idx_q;
        sb_ofs_e    = start_c ? '0 : sb_ofs_q;
        in_last_c   = (in_idx_e == (num_in_e - CNT_W'(1)));
        out_last_c  = (out_idx_e == (num_out_e - CNT_W'(1)));
        issue_c     = (state_d == S_RUN) && (credits_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            credits_q   <= CNT_W'(CREDITS);
            rd_q        <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_nbin_addr <= '0;
            o_sb_addr   <= '0;
            num_in_q    <= '0;
            num_out_q   <= '0;
            nbin_base_q <= '0;
            sb_base_q   <= '0;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            sb_ofs_q    <= '0;
            iss_first_q <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_end_q   <= 1'b0;
            pv_q        <= '0;
            pf_q        <= '0;
            pl_q        <= '0;
        end else begin
            state     <= state_d;
            credits_q <= credits_d;
            rd_q      <= issue_c;
            o_busy    <= (state_d != S_IDLE);
            o_done    <= (state_d == S_DONE);

            if (start_c) begin
                num_in_q    <= i_num_in;
                num_out_q   <= i_num_out;
                nbin_base_q <= i_nbin_base;
                sb_base_q   <= i_sb_base;
                in_idx_q    <= '0;
                out_idx_q   <= '0;
                sb_ofs_q    <= '0;
            end

            if (issue_c) begin
                o_nbin_addr <= nbin_base_e + ADDR_W'(in_idx_e);
                o_sb_addr   <= sb_base_e + sb_ofs_e;
                iss_first_q <= (in_idx_e == '0);
                iss_last_q  <= in_last_c;
                iss_end_q   <= in_last_c && out_last_c;
                sb_ofs_q    <= sb_ofs_e + ADDR_W'(1);
                if (in_last_c) begin
                    in_idx_q  <= '0;
                    out_idx_q <= out_idx_e + CNT_W'(1);
                end else begin
                    in_idx_q  <= in_idx_e + CNT_W'(1);
                end
            end

            pv_q <= {pv_q[D-2:0], rd_q};
            pf_q <= {pf_q[D-2:0], rd_q & iss_first_q};
            pl_q <= {pl_q[D-2:0], rd_q & iss_last_q};
        end
    end

    assign o_nbin_rd = rd_q;
    assign o_sb_rd   = rd_q;
    assign o_valid   = pv_q[D-1];
    assign o_first   = pf_q[D-1];
    assign o_last    = pl_q[D-1];
    assign o_credits = credits_q;

endmodule

// File: tb/tb_n0_sched.sv
// Directed bench for n0_sched: main instance with CREDITS=8, second with CREDITS=2 for starvation.
module tb_n0_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2, credit1, credit2;
    logic [9:0] num_in, num_out, nbin_base, sb_base;

    logic       busy1, done1, nrd1, srd1, v1, f1, l1;
    logic [9:0] naddr1, saddr1, cr1;
    logic       busy2, done2, nrd2, srd2, v2, f2, l2;
    logic [9:0] naddr2, saddr2, cr2;

    int total = 0;
    int bad   = 0;
    bit credit_lvl = 1'b0;

    logic       c_rd[64], c_srd[64], c_v[64], c_f[64], c_l[64], c_dn[64], c_busy[64];
    logic [9:0] c_nb[64], c_sb[64], c_cr[64];

    always #5 clk = ~clk;

    n0_sched #(.ADDR_W(10), .CNT_W(10), .LAT(5), .CREDITS(8)) u_dut (
        .clk(clk), .rst(rst), .i_start(start1), .i_num_in(num_in), .i_num_out(num_out),
        .i_nbin_base(nbin_base), .i_sb_base(sb_base), .i_credit(credit1),
        .o_busy(busy1), .o_done(done1), .o_nbin_rd(nrd1), .o_nbin_addr(naddr1),
        .o_sb_rd(srd1), .o_sb_addr(saddr1), .o_valid(v1), .o_first(f1), .o_last(l1),
        .o_credits(cr1)
    );

    n0_sched #(.ADDR_W(10), .CNT_W(10), .LAT(5), .CREDITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_num_in(num_in), .i_num_out(num_out),
        .i_nbin_base(nbin_base), .i_sb_base(sb_base), .i_credit(credit2),
        .o_busy(busy2), .o_done(done2), .o_nbin_rd(nrd2), .o_nbin_addr(naddr2),
        .o_sb_rd(srd2), .o_sb_addr(saddr2), .o_valid(v2), .o_first(f2), .o_last(l2),
        .o_credits(cr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one window of cycles and record outputs; cycle 0 is where i_start is applied.
    task automatic capture(input bit sel, input int ncyc, input int start_at,
                           input int restart_at, input int credit_at, input int rst_at);
        for (int j = 0; j < ncyc; j++) begin
            rst = (j == rst_at);
            if (sel) begin
                start2  = (j == start_at) || (j == restart_at);
                credit2 = (j == credit_at) || credit_lvl;
                c_rd[j] = nrd2; c_srd[j] = srd2; c_nb[j] = naddr2; c_sb[j] = saddr2;
                c_v[j] = v2; c_f[j] = f2; c_l[j] = l2; c_dn[j] = done2;
                c_busy[j] = busy2; c_cr[j] = cr2;
            end else begin
                start1  = (j == start_at) || (j == restart_at);
                credit1 = (j == credit_at) || credit_lvl;
                c_rd[j] = nrd1; c_srd[j] = srd1; c_nb[j] = naddr1; c_sb[j] = saddr1;
                c_v[j] = v1; c_f[j] = f1; c_l[j] = l1; c_dn[j] = done1;
                c_busy[j] = busy1; c_cr[j] = cr1;
            end
            tick();
        end
        start1 = 1'b0;
        start2 = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if ({busy1, done1, nrd1, srd1, v1, f1, l1} !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {busy1, done1, nrd1, srd1, v1, f1, l1}); end
        total++; if (naddr1 !== 10'h0 || saddr1 !== 10'h0) begin bad++; $display("FAIL reset_addr got=%h/%h exp=0/0", naddr1, saddr1); end
        total++; if (cr1 !== 10'd8) begin bad++; $display("FAIL reset_credits got=%0d exp=8", cr1); end
        total++; if (cr2 !== 10'd2) begin bad++; $display("FAIL reset_credits2 got=%0d exp=2", cr2); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_credit_sat();
        credit1 = 1'b1;
        repeat (3) tick();
        total++; if (cr1 !== 10'd8) begin bad++; $display("FAIL credit_sat got=%0d exp=8", cr1); end
        credit1 = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        num_in = 10'd3; num_out = 10'd2; nbin_base = 10'h10; sb_base = 10'h100;
        credit_lvl = 1'b1;
        capture(1'b0, 20, 0, -1, -1, -1);
        n = 0;
        for (int j = 0; j < 20; j++) begin
            total++; if (c_rd[j] !== (j >= 1 && j <= 6)) begin bad++; $display("FAIL basic_rd cyc=%0d got=%b", j, c_rd[j]); end
            total++; if (c_srd[j] !== (j >= 1 && j <= 6)) begin bad++; $display("FAIL basic_sbrd cyc=%0d got=%b", j, c_srd[j]); end
            if (j >= 1 && j <= 6) begin
                total++; if (c_nb[j] !== 10'(10'h10 + (j - 1) % 3)) begin bad++; $display("FAIL basic_nb cyc=%0d got=%h exp=%h", j, c_nb[j], 10'(10'h10 + (j - 1) % 3)); end
                total++; if (c_sb[j] !== 10'(10'h100 + j - 1)) begin bad++; $display("FAIL basic_sb cyc=%0d got=%h exp=%h", j, c_sb[j], 10'(10'h100 + j - 1)); end
            end
            total++; if (c_v[j] !== (j >= 7 && j <= 12)) begin bad++; $display("FAIL basic_valid cyc=%0d got=%b", j, c_v[j]); end
            total++; if (c_f[j] !== (j == 7 || j == 10)) begin bad++; $display("FAIL basic_first cyc=%0d got=%b", j, c_f[j]); end
            total++; if (c_l[j] !== (j == 9 || j == 12)) begin bad++; $display("FAIL basic_last cyc=%0d got=%b", j, c_l[j]); end
            total++; if (c_dn[j] !== (j == 13)) begin bad++; $display("FAIL basic_done cyc=%0d got=%b", j, c_dn[j]); end
            total++; if (c_busy[j] !== (j >= 1 && j <= 13)) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b", j, c_busy[j]); end
            total++; if (c_cr[j] !== 10'd8) begin bad++; $display("FAIL basic_credits cyc=%0d got=%0d exp=8", j, c_cr[j]); end
            if (c_rd[j] === 1'b1) n++;
        end
        total++; if (n != 6) begin bad++; $display("FAIL basic_issues got=%0d exp=6", n); end
        total++; if (c_nb[15] !== 10'h12 || c_sb[15] !== 10'h105) begin bad++; $display("FAIL basic_hold got=%h/%h exp=012/105", c_nb[15], c_sb[15]); end
    endtask

    task automatic test_single_in();
        num_in = 10'd1; num_out = 10'd3; nbin_base = 10'h20; sb_base = 10'h40;
        credit_lvl = 1'b1;
        capture(1'b0, 16, 0, -1, -1, -1);
        for (int j = 0; j < 16; j++) begin
            total++; if (c_rd[j] !== (j >= 1 && j <= 3)) begin bad++; $display("FAIL single_rd cyc=%0d got=%b", j, c_rd[j]); end
            if (j >= 1 && j <= 3) begin
                total++; if (c_nb[j] !== 10'h20) begin bad++; $display("FAIL single_nb cyc=%0d got=%h exp=020", j, c_nb[j]); end
                total++; if (c_sb[j] !== 10'(10'h40 + j - 1)) begin bad++; $display("FAIL single_sb cyc=%0d got=%h exp=%h", j, c_sb[j], 10'(10'h40 + j - 1)); end
            end
            total++; if (c_v[j] !== (j >= 7 && j <= 9)) begin bad++; $display("FAIL single_valid cyc=%0d got=%b", j, c_v[j]); end
            total++; if (c_f[j] !== c_v[j] || c_l[j] !== (j >= 7 && j <= 9)) begin bad++; $display("FAIL single_fl cyc=%0d got=%b%b", j, c_f[j], c_l[j]); end
            total++; if (c_dn[j] !== (j == 10)) begin bad++; $display("FAIL single_done cyc=%0d got=%b", j, c_dn[j]); end
        end
    endtask

    task automatic test_zero_len();
        num_in = 10'd4; num_out = 10'd0; nbin_base = 10'h0; sb_base = 10'h0;
        credit_lvl = 1'b1;
        capture(1'b0, 6, 0, -1, -1, -1);
        for (int j = 0; j < 6; j++) begin
            total++; if (c_rd[j] !== 1'b0 || c_srd[j] !== 1'b0) begin bad++; $display("FAIL zero_rd cyc=%0d got=%b%b", j, c_rd[j], c_srd[j]); end
            total++; if (c_dn[j] !== (j == 1)) begin bad++; $display("FAIL zero_done cyc=%0d got=%b", j, c_dn[j]); end
        end
    endtask

    task automatic test_start_ignored();
        int n, d;
        num_in = 10'd2; num_out = 10'd2; nbin_base = 10'h0; sb_base = 10'h0;
        credit_lvl = 1'b1;
        capture(1'b0, 25, 0, 3, -1, -1);
        n = 0; d = 0;
        for (int j = 0; j < 25; j++) begin
            if (c_rd[j] === 1'b1) n++;
            if (c_dn[j] === 1'b1) d++;
        end
        total++; if (n != 4) begin bad++; $display("FAIL restart_issues got=%0d exp=4", n); end
        total++; if (d != 1) begin bad++; $display("FAIL restart_done got=%0d exp=1", d); end
        total++; if (c_dn[11] !== 1'b1) begin bad++; $display("FAIL restart_done_cyc got=%b exp=1", c_dn[11]); end
    endtask

    task automatic test_starve();
        int n, d;
        num_in = 10'd4; num_out = 10'd1; nbin_base = 10'h0; sb_base = 10'h0;
        credit_lvl = 1'b0;
        capture(1'b1, 20, 0, -1, 9, -1);
        for (int j = 0; j < 20; j++) begin
            total++; if (c_rd[j] !== (j == 1 || j == 2 || j == 10)) begin bad++; $display("FAIL starve_rd cyc=%0d got=%b", j, c_rd[j]); end
        end
        total++; if (c_cr[5] !== 10'd0) begin bad++; $display("FAIL starve_cr5 got=%0d exp=0", c_cr[5]); end
        total++; if (c_cr[10] !== 10'd1) begin bad++; $display("FAIL starve_cr10 got=%0d exp=1", c_cr[10]); end
        total++; if (c_cr[15] !== 10'd0) begin bad++; $display("FAIL starve_cr15 got=%0d exp=0", c_cr[15]); end
        credit_lvl = 1'b1;
        capture(1'b1, 20, -1, -1, -1, -1);
        n = 0; d = 0;
        for (int j = 0; j < 20; j++) begin
            if (c_rd[j] === 1'b1) n++;
            if (c_dn[j] === 1'b1) d++;
        end
        total++; if (n != 1) begin bad++; $display("FAIL starve_tail_issues got=%0d exp=1", n); end
        total++; if (d != 1) begin bad++; $display("FAIL starve_done got=%0d exp=1", d); end
        total++; if (c_busy[19] !== 1'b0 || c_cr[19] !== 10'd2) begin bad++; $display("FAIL starve_end got busy=%b cr=%0d exp 0/2", c_busy[19], c_cr[19]); end
        credit_lvl = 1'b0;
        credit2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, v, d;
        num_in = 10'd4; num_out = 10'd2; nbin_base = 10'h0; sb_base = 10'h0;
        credit_lvl = 1'b0;
        capture(1'b0, 20, 0, -1, -1, 3);
        total++; if (c_cr[3] !== 10'd6) begin bad++; $display("FAIL rstmid_cr_before got=%0d exp=6", c_cr[3]); end
        for (int j = 4; j < 20; j++) begin
            total++; if (c_v[j] !== 1'b0 || c_busy[j] !== 1'b0 || c_rd[j] !== 1'b0) begin bad++; $display("FAIL rstmid_quiet cyc=%0d got v=%b busy=%b rd=%b", j, c_v[j], c_busy[j], c_rd[j]); end
            total++; if (c_cr[j] !== 10'd8) begin bad++; $display("FAIL rstmid_credits cyc=%0d got=%0d exp=8", j, c_cr[j]); end
        end
        num_in = 10'd2; num_out = 10'd1; credit_lvl = 1'b1;
        capture(1'b0, 16, 0, -1, -1, -1);
        n = 0; v = 0; d = 0;
        for (int j = 0; j < 16; j++) begin
            if (c_rd[j] === 1'b1) n++;
            if (c_v[j] === 1'b1) v++;
            if (c_dn[j] === 1'b1) d++;
        end
        total++; if (n != 2 || v != 2 || d != 1) begin bad++; $display("FAIL rstmid_fresh got issues=%0d valids=%0d dones=%0d exp 2/2/1", n, v, d); end
        total++; if (c_dn[9] !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_done got=%b exp=1", c_dn[9]); end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_sb[4];
        logic [9:0] exp_nb[4];
        exp_sb = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        exp_nb = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        num_in = 10'd4; num_out = 10'd1; nbin_base = 10'h3FD; sb_base = 10'h3FE;
        credit_lvl = 1'b1;
        capture(1'b0, 14, 0, -1, -1, -1);
        for (int k = 0; k < 4; k++) begin
            total++; if (c_rd[k+1] !== 1'b1) begin bad++; $display("FAIL wrap_rd idx=%0d got=%b exp=1", k, c_rd[k+1]); end
            total++; if (c_sb[k+1] !== exp_sb[k]) begin bad++; $display("FAIL wrap_sb idx=%0d got=%h exp=%h", k, c_sb[k+1], exp_sb[k]); end
            total++; if (c_nb[k+1] !== exp_nb[k]) begin bad++; $display("FAIL wrap_nb idx=%0d got=%h exp=%h", k, c_nb[k+1], exp_nb[k]); end
        end
        total++; if (c_rd[5] !== 1'b0) begin bad++; $display("FAIL wrap_stop got=%b exp=0", c_rd[5]); end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; credit1 = 1'b0; credit2 = 1'b0;
        num_in = '0; num_out = '0; nbin_base = '0; sb_base = '0;
        tick();
        test_reset();
        test_credit_sat();
        test_basic();
        test_single_in();
        test_zero_len();
        test_start_ignored();
        test_starve();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
